// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong splitter/merger pair: lane encoding,
// arbiter states and the default stream width.
package pingpong_pkg;

  localparam int DW_DEFAULT = 512;

  localparam logic PATH_LANE1 = 1'b0;
  localparam logic PATH_LANE2 = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // A group size of zero would never complete, so it behaves as one packet.
  function automatic logic [31:0] eff_group(input logic [31:0] pp_group);
    return (pp_group == 32'd0) ? 32'd1 : pp_group;
  endfunction

endpackage

// File: rtl/axis_fwd_reg.sv
// Single-entry AXI-stream forward register slice: registers the payload and
// valid, with ready passed straight through from the downstream side.
module axis_fwd_reg #(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [DW-1:0]   s_tdata_i,
  input  logic [DW/8-1:0] s_tkeep_i,
  input  logic            s_tlast_i,
  input  logic            s_tvalid_i,
  output logic            s_tready_o,
  output logic [DW-1:0]   m_tdata_o,
  output logic [DW/8-1:0] m_tkeep_o,
  output logic            m_tlast_o,
  output logic            m_tvalid_o,
  input  logic            m_tready_i
);

  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] keep_q;
  logic            last_q;
  logic            valid_q;

  assign s_tready_o = !valid_q || m_tready_i;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (s_tready_o) begin
      valid_q <= s_tvalid_i;
      if (s_tvalid_i) begin
        data_q <= s_tdata_i;
        keep_q <= s_tkeep_i;
        last_q <= s_tlast_i;
      end
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tlast_o  = last_q;
  assign m_tvalid_o = valid_q;

endmodule

// File: rtl/pingpong_merger.sv
// Recombines the two ping-pong lanes into one stream, alternating PP_GROUP
// packets per lane and restarting on lane 1 at every frame boundary.
//
// state  | meaning
// IDLE   | no beat accepted yet in this frame; live config drives decisions
// ACTIVE | frame in progress; config latched at the first accepted beat
module pingpong_merger
  import pingpong_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     FRAME_SIZE,
  input  logic [31:0]     PP_GROUP,
  output logic            path,
  output logic            frame_done,
  input  logic [DW-1:0]   AXIS_IN1_TDATA,
  input  logic [DW/8-1:0] AXIS_IN1_TKEEP,
  input  logic            AXIS_IN1_TLAST,
  input  logic            AXIS_IN1_TVALID,
  output logic            AXIS_IN1_TREADY,
  input  logic [DW-1:0]   AXIS_IN2_TDATA,
  input  logic [DW/8-1:0] AXIS_IN2_TKEEP,
  input  logic            AXIS_IN2_TLAST,
  input  logic            AXIS_IN2_TVALID,
  output logic            AXIS_IN2_TREADY,
  output logic [DW-1:0]   AXIS_OUT_TDATA,
  output logic [DW/8-1:0] AXIS_OUT_TKEEP,
  output logic            AXIS_OUT_TLAST,
  output logic            AXIS_OUT_TVALID,
  input  logic            AXIS_OUT_TREADY
);

  state_e      state_q, state_d;
  logic        path_q, path_d;
  logic [31:0] group_cnt_q, group_cnt_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] frame_size_q, frame_size_d;
  logic [31:0] pp_group_q, pp_group_d;
  logic        frame_done_q;

  logic [DW-1:0]   sel_tdata;
  logic [DW/8-1:0] sel_tkeep;
  logic            sel_tlast;
  logic            sel_tvalid;
  logic            load;
  logic            accept;
  logic            pkt_end;
  logic            frame_end;
  logic            group_end;
  logic [31:0]     cfg_frame;
  logic [31:0]     cfg_grp;

  assign sel_tdata  = (path_q == PATH_LANE2) ? AXIS_IN2_TDATA  : AXIS_IN1_TDATA;
  assign sel_tkeep  = (path_q == PATH_LANE2) ? AXIS_IN2_TKEEP  : AXIS_IN1_TKEEP;
  assign sel_tlast  = (path_q == PATH_LANE2) ? AXIS_IN2_TLAST  : AXIS_IN1_TLAST;
  assign sel_tvalid = (path_q == PATH_LANE2) ? AXIS_IN2_TVALID : AXIS_IN1_TVALID;

  axis_fwd_reg #(.DW(DW)) u_out_reg (
    .clk        (clk),
    .resetn     (resetn),
    .s_tdata_i  (sel_tdata),
    .s_tkeep_i  (sel_tkeep),
    .s_tlast_i  (sel_tlast),
    .s_tvalid_i (sel_tvalid),
    .s_tready_o (load),
    .m_tdata_o  (AXIS_OUT_TDATA),
    .m_tkeep_o  (AXIS_OUT_TKEEP),
    .m_tlast_o  (AXIS_OUT_TLAST),
    .m_tvalid_o (AXIS_OUT_TVALID),
    .m_tready_i (AXIS_OUT_TREADY)
  );

  assign accept    = resetn && sel_tvalid && load;
  assign pkt_end   = accept && sel_tlast;
  assign frame_end = pkt_end && (cfg_frame != 32'd0) && (frame_cnt_q == cfg_frame - 32'd1);
  assign group_end = pkt_end && (group_cnt_q == cfg_grp - 32'd1);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !frame_end) state_d = ACTIVE;
      ACTIVE:  if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the first beat of the frame is being decided with the live config.
  always_comb begin
    cfg_frame       = (state_q == IDLE) ? FRAME_SIZE : frame_size_q;
    cfg_grp         = eff_group((state_q == IDLE) ? PP_GROUP : pp_group_q);
    AXIS_IN1_TREADY = resetn && load && (path_q == PATH_LANE1);
    AXIS_IN2_TREADY = resetn && load && (path_q == PATH_LANE2);
  end

  always_comb begin
    group_cnt_d  = group_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    path_d       = path_q;
    frame_size_d = frame_size_q;
    pp_group_d   = pp_group_q;
    if ((state_q == IDLE) && accept) begin
      frame_size_d = FRAME_SIZE;
      pp_group_d   = PP_GROUP;
    end
    if (frame_end) begin
      group_cnt_d = '0;
      frame_cnt_d = '0;
      path_d      = PATH_LANE1;
    end else if (group_end) begin
      group_cnt_d = '0;
      frame_cnt_d = frame_cnt_q + 32'd1;
      path_d      = ~path_q;
    end else if (pkt_end) begin
      group_cnt_d = group_cnt_q + 32'd1;
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      path_q       <= PATH_LANE1;
      group_cnt_q  <= '0;
      frame_cnt_q  <= '0;
      frame_size_q <= '0;
      pp_group_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      path_q       <= path_d;
      group_cnt_q  <= group_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_size_q <= frame_size_d;
      pp_group_q   <= pp_group_d;
      frame_done_q <= frame_end;
    end
  end

  assign path       = path_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pingpong_merger.sv
// Randomized bench for pingpong_merger: a packet-level model predicts the merged
// order and frame boundaries, and a scoreboard checks every output beat.
module tb_pingpong_merger;
  import pingpong_pkg::*;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int BW = DW + KW + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   frame_size = 32'd0;
  logic [31:0]   pp_group = 32'd1;
  logic          path, frame_done;
  logic [DW-1:0] in1_tdata, in2_tdata, out_tdata;
  logic [KW-1:0] in1_tkeep, in2_tkeep, out_tkeep;
  logic          in1_tlast, in2_tlast, out_tlast;
  logic          in1_tvalid, in2_tvalid, out_tvalid;
  logic          in1_tready, in2_tready, out_tready;

  always #5 clk = ~clk;

  pingpong_merger #(.DW(DW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .FRAME_SIZE      (frame_size),
    .PP_GROUP        (pp_group),
    .path            (path),
    .frame_done      (frame_done),
    .AXIS_IN1_TDATA  (in1_tdata),
    .AXIS_IN1_TKEEP  (in1_tkeep),
    .AXIS_IN1_TLAST  (in1_tlast),
    .AXIS_IN1_TVALID (in1_tvalid),
    .AXIS_IN1_TREADY (in1_tready),
    .AXIS_IN2_TDATA  (in2_tdata),
    .AXIS_IN2_TKEEP  (in2_tkeep),
    .AXIS_IN2_TLAST  (in2_tlast),
    .AXIS_IN2_TVALID (in2_tvalid),
    .AXIS_IN2_TREADY (in2_tready),
    .AXIS_OUT_TDATA  (out_tdata),
    .AXIS_OUT_TKEEP  (out_tkeep),
    .AXIS_OUT_TLAST  (out_tlast),
    .AXIS_OUT_TVALID (out_tvalid),
    .AXIS_OUT_TREADY (out_tready)
  );

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] l1_q[$];
  logic [BW-1:0] l2_q[$];
  logic [BW:0]   exp_q[$];

  int in_valid_pct  = 100;
  int out_ready_pct = 100;
  bit hs1 = 1'b0, hs2 = 1'b0;
  int cyc = 0, first_cyc = -1, last_cyc = -1;
  int tlast_seen = 0, beats_seen = 0;
  bit fd_flag = 1'b0;
  bit prev_stall = 1'b0;
  logic [BW-1:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: lane choice per packet from group/frame counting rules.
  task automatic build(input int n, input int blen, input int fs, input int g0, input int g1);
    int p, gc, fc, fr, g, len;
    logic [BW-1:0] b;
    bit fd;
    p = 0; gc = 0; fc = 0; fr = 0;
    for (int k = 0; k < n; k++) begin
      len = (blen != 0) ? blen : int'($urandom_range(1, 4));
      g = (fr == 0) ? g0 : g1;
      if (g == 0) g = 1;
      fc++; gc++;
      fd = (fs != 0) && (fc == fs);
      for (int j = 0; j < len; j++) begin
        b = {(j == len - 1), 4'($urandom_range(1, 15)), 8'(p + 1), 8'(k), 8'(j), 8'($urandom)};
        if (p == 0) l1_q.push_back(b);
        else        l2_q.push_back(b);
        exp_q.push_back({fd && (j == len - 1), b});
      end
      if (fd) begin
        fc = 0; gc = 0; p = 0; fr++;
      end else if (gc == g) begin
        gc = 0; p ^= 1;
      end
    end
  endtask

  // Lane drivers and output monitor: drive on the falling edge, sample 1 time unit later.
  initial begin
    in1_tvalid = 1'b0; in1_tdata = '0; in1_tkeep = '0; in1_tlast = 1'b0;
    in2_tvalid = 1'b0; in2_tdata = '0; in2_tkeep = '0; in2_tlast = 1'b0;
    out_tready = 1'b1;
    forever begin
      @(negedge clk);
      if (hs1 && l1_q.size() > 0) void'(l1_q.pop_front());
      if (hs2 && l2_q.size() > 0) void'(l2_q.pop_front());
      if (l1_q.size() > 0 && ((in1_tvalid && !hs1) || $urandom_range(0, 99) < in_valid_pct)) begin
        in1_tvalid = 1'b1;
        {in1_tlast, in1_tkeep, in1_tdata} = l1_q[0];
      end else in1_tvalid = 1'b0;
      if (l2_q.size() > 0 && ((in2_tvalid && !hs2) || $urandom_range(0, 99) < in_valid_pct)) begin
        in2_tvalid = 1'b1;
        {in2_tlast, in2_tkeep, in2_tdata} = l2_q[0];
      end else in2_tvalid = 1'b0;
      out_tready = ($urandom_range(0, 99) < out_ready_pct);
      #1;
      hs1 = in1_tvalid && in1_tready;
      hs2 = in2_tvalid && in2_tready;
      cyc++;
      if (!resetn) begin
        chk("rdy_in_reset", {in1_tready, in2_tready}, 2'b00);
        prev_stall = 1'b0;
        fd_flag = 1'b0;
      end else begin
        chk("rdy1_gate", in1_tready && path, 1'b0);
        chk("rdy2_gate", in2_tready && !path, 1'b0);
        chk("rdy_load", path ? in2_tready : in1_tready, !out_tvalid || out_tready);
        if (prev_stall)
          chk("stall_hold", {out_tvalid, out_tlast, out_tkeep, out_tdata}, {1'b1, prev_out});
        if (frame_done) begin
          chk("fd_with_valid", out_tvalid, 1'b1);
          fd_flag = 1'b1;
        end
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", {out_tlast, out_tkeep, out_tdata}, '0);
          else chk("beat", {fd_flag, out_tlast, out_tkeep, out_tdata}, exp_q.pop_front());
          fd_flag = 1'b0;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          beats_seen++;
          if (out_tlast) tlast_seen++;
        end
        prev_stall = out_tvalid && !out_tready;
        prev_out = {out_tlast, out_tkeep, out_tdata};
      end
    end
  end

  task automatic start_phase(input int fs, input int pg, input int vpct, input int rpct);
    @(negedge clk); #3;
    resetn = 1'b0;
    l1_q.delete(); l2_q.delete(); exp_q.delete();
    hs1 = 1'b0; hs2 = 1'b0;
    @(negedge clk); #3;
    frame_size = 32'(fs); pp_group = 32'(pg);
    in_valid_pct = vpct; out_ready_pct = rpct;
    first_cyc = -1; last_cyc = -1; tlast_seen = 0; beats_seen = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk); n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #3 chk({tag, "_lanes_empty"}, l1_q.size() + l2_q.size(), 0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #3;
    chk("rst_out", {out_tvalid, out_tlast, out_tkeep, out_tdata}, '0);
    chk("rst_path_fd", {path, frame_done}, 2'b00);
    resetn = 1'b1;

    // Group of 2, no frames, full throughput: L1,L1,L2,L2,L1,L1 with no bubble
    start_phase(0, 2, 100, 100);
    build(6, 4, 0, 2, 2);
    resetn = 1'b1;
    drain("grp2_order", 400);
    chk("no_bubble", last_cyc - first_cyc, 23);

    // Frame of 3 with groups of 2: third packet ends frame, next restarts on lane 1
    start_phase(3, 2, 100, 100);
    build(7, 4, 3, 2, 2);
    resetn = 1'b1;
    drain("frame3", 400);

    // Random lengths, valid gaps and 50% downstream backpressure
    start_phase(5, 3, 70, 50);
    build(20, 0, 5, 3, 3);
    resetn = 1'b1;
    drain("backpressure", 2000);

    // PP_GROUP=0 acts as 1; mid-frame change to 2 applies only from the next frame
    start_phase(4, 0, 80, 60);
    build(12, 0, 4, 1, 2);
    resetn = 1'b1;
    begin
      int n;
      n = 0;
      while (tlast_seen < 2 && n < 500) begin
        @(negedge clk); n++;
      end
      chk("wait_mid_frame", tlast_seen >= 2, 1'b1);
    end
    #3 pp_group = 32'd2;
    drain("grp0_then_2", 2000);

    // One-cycle reset in the middle of the first packet
    start_phase(2, 1, 100, 100);
    build(4, 4, 2, 1, 1);
    resetn = 1'b1;
    begin
      int n;
      n = 0;
      while (beats_seen < 2 && n < 200) begin
        @(negedge clk); n++;
      end
      chk("wait_mid_packet", beats_seen >= 2, 1'b1);
    end
    #3;
    resetn = 1'b0;
    l1_q.delete(); l2_q.delete(); exp_q.delete();
    hs1 = 1'b0; hs2 = 1'b0;
    @(negedge clk); #3;
    chk("mid_rst_valid", out_tvalid, 1'b0);
    chk("mid_rst_path", {path, frame_done}, 2'b00);
    build(4, 4, 2, 1, 1);
    resetn = 1'b1;
    drain("after_reset", 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
